floo_latency_emulator: RTL and testbench



---
 rtl/floo_latency_emulator_pkg.sv | 22 ++
 rtl/floo_lfsr16.sv | 32 +++
 rtl/floo_latency_emulator.sv | 153 +++++++++++++++
 tb/tb_floo_latency_emulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_latency_emulator_pkg.sv
// Shared definitions for the FlooNoC latency emulator.
//   slave_type_e        : runtime latency mode (2-bit encoding, 3 acts as slow)
//   Default*            : default latency / seed values used by the emulator
//   lfsr16_next         : one step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
package floo_latency_emulator_pkg;

    typedef enum logic [1:0] {
        FastSlave    = 2'd0,
        SlowSlave    = 2'd1,
        MixedSlave   = 2'd2,
        SlowSlaveAlt = 2'd3
    } slave_type_e;

    localparam int unsigned DefaultFastLatency = 1;
    localparam int unsigned DefaultSlowLatency = 8;
    localparam logic [15:0] DefaultLfsrSeed    = 16'hACE1;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
        return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    endfunction

endpackage

// File: rtl/floo_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick per-beat latency in mixed mode.
//   clk_i, rst_ni : clock, asynchronous active-low reset (loads Seed)
//   en_i          : advance one step
//   clear_i       : synchronous reload of Seed, wins over en_i
//   state_o       : current LFSR state
module floo_lfsr16
    import floo_latency_emulator_pkg::*;
#(
    parameter logic [15:0] Seed = DefaultLfsrSeed
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clear_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Seed;
        end else if (clear_i) begin
            state_q <= Seed;
        end else if (en_i) begin
            state_q <= lfsr16_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/floo_latency_emulator.sv
// In-order latency emulator placed in front of a slave model / response port.
// Each accepted beat is held for a mode-dependent latency, then released in
// strict arrival order.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous flush of all entries and LFSR reseed
//   mode_i         : slave_type_e (fast / slow / mixed, 3 = slow)
//   valid_i/ready_o/data_i : input beat handshake
//   valid_o/ready_i/data_o : delayed output beat handshake
//   occupancy_o    : number of stored entries
module floo_latency_emulator
    import floo_latency_emulator_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 4,
    parameter int unsigned FastLatency = DefaultFastLatency,
    parameter int unsigned SlowLatency = DefaultSlowLatency,
    parameter logic [15:0] LfsrSeed    = DefaultLfsrSeed
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [1:0]                   mode_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DataWidth-1:0]         data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

    localparam int unsigned CntW = $clog2(SlowLatency + 1);
    localparam int unsigned OccW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [OccW-1:0] occ_t;

    localparam cnt_t FastLoad = cnt_t'(FastLatency - 1);
    localparam cnt_t SlowLoad = cnt_t'(SlowLatency - 1);
    localparam ptr_t LastIdx  = ptr_t'(Depth - 1);
    localparam occ_t DepthCnt = occ_t'(Depth);

    logic [DataWidth-1:0] data_q [Depth];
    cnt_t                 cnt_q  [Depth];
    logic [Depth-1:0]     occ_q;
    ptr_t                 wr_q, rd_q;
    occ_t                 count_q, count_d;
    logic                 ready_q;

    logic        push, pop;
    cnt_t        load_cnt;
    logic [15:0] lfsr_state;
    logic        lfsr_unused;
    slave_type_e mode;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastIdx) ? '0 : p + ptr_t'(1);
    endfunction

    floo_lfsr16 #(.Seed(LfsrSeed)) i_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (push),
        .clear_i (clear_i),
        .state_o (lfsr_state)
    );

    // Only bit 0 drives the latency choice.
    assign lfsr_unused = ^lfsr_state[15:1];

    assign mode    = slave_type_e'(mode_i);
    assign valid_o = (count_q != '0) && (cnt_q[rd_q] == '0);
    assign data_o  = data_q[rd_q];
    assign ready_o = ready_q;
    assign occupancy_o = count_q;

    assign push = valid_i && ready_q && !clear_i;
    assign pop  = valid_o && ready_i && !clear_i;

    always_comb begin
        load_cnt = SlowLoad;
        case (mode)
            FastSlave:  load_cnt = FastLoad;
            MixedSlave: load_cnt = lfsr_state[0] ? SlowLoad : FastLoad;
            default:    load_cnt = SlowLoad;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + occ_t'(1);
            2'b01:   count_d = count_q - occ_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else if (clear_i) begin
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            // Countdown runs on every occupied entry, not just the head, so a
            // short beat queued behind a long one is ready as soon as it reaches
            // the head.
            for (int unsigned i = 0; i < Depth; i++) begin
                if (occ_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - cnt_t'(1);
                end
            end
            if (pop) begin
                occ_q[rd_q] <= 1'b0;
                rd_q        <= ptr_inc(rd_q);
            end
            if (push) begin
                data_q[wr_q] <= data_i;
                cnt_q[wr_q]  <= load_cnt;
                occ_q[wr_q]  <= 1'b1;
                wr_q         <= ptr_inc(wr_q);
            end
            count_q <= count_d;
            ready_q <= (count_d != DepthCnt);
        end
    end

`ifndef SYNTHESIS
    a_fast_lat: assert property (@(posedge clk_i) FastLatency >= 1)
        else $error("FastLatency must be >= 1");
    a_slow_lat: assert property (@(posedge clk_i) SlowLatency >= FastLatency)
        else $error("SlowLatency must be >= FastLatency");
    a_seed: assert property (@(posedge clk_i) LfsrSeed != 16'h0)
        else $error("LfsrSeed must be nonzero");
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !clear_i) |=> $stable(data_o))
        else $error("data_o changed while stalled");
`endif

endmodule

// File: tb/tb_floo_latency_emulator.sv
module tb_floo_latency_emulator;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [1:0]  mode_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [2:0]  occupancy_o;

    int checks = 0;
    int errors = 0;

    floo_latency_emulator #(
        .DataWidth   (32),
        .Depth       (4),
        .FastLatency (1),
        .SlowLatency (8),
        .LfsrSeed    (16'hACE1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .mode_i      (mode_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single beats in mixed mode, each drained before the next; the model LFSR
    // starts from the seed, so the DUT must have been cleared or reset just before.
    task automatic mixed_run(input int nbeats);
        logic [15:0] m;
        int          exp_lat;
        int          n;
        m = 16'hACE1;
        mode_i  = 2'd2;
        ready_i = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            exp_lat = m[0] ? 8 : 1;
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
            valid_i = 1'b1;
            data_i  = 32'h1000 + k;
            step();
            valid_i = 1'b0;
            n = 1;
            while (!valid_o && n < 20) begin
                step();
                n++;
            end
            check("mixed_lat", n, exp_lat);
            check("mixed_data", data_o, 32'h1000 + k);
            step();
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        mode_i  = 2'd0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        repeat (3) step();
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_occ", occupancy_o, 0);
        check("rst_data", data_o, 0);
        rst_ni = 1'b1;
        step();

        // Fast mode: single beat, latency 1
        mode_i  = 2'd0;
        valid_i = 1'b1;
        data_i  = 32'hA5;
        check("fast_c0_valid", valid_o, 0);
        step();
        valid_i = 1'b0;
        check("fast_c1_valid", valid_o, 1);
        check("fast_c1_data", data_o, 32'hA5);
        check("fast_c1_occ", occupancy_o, 1);
        step();
        check("fast_c2_occ", occupancy_o, 0);
        check("fast_c2_valid", valid_o, 0);

        // Slow mode: 4 back-to-back beats, released at 8..11
        mode_i = 2'd1;
        for (int c = 0; c < 4; c++) begin
            valid_i = 1'b1;
            data_i  = 32'h10 + c;
            step();
        end
        valid_i = 1'b0;
        check("slow_full_ready", ready_o, 0);
        check("slow_full_occ", occupancy_o, 4);
        for (int c = 4; c <= 12; c++) begin
            check("slow_valid", valid_o, (c >= 8 && c <= 11));
            if (c >= 8 && c <= 11) check("slow_data", data_o, 32'h10 + c - 8);
            if (c == 8) check("slow_ready_c8", ready_o, 0);
            if (c == 9) check("slow_ready_c9", ready_o, 1);
            step();
        end
        check("slow_end_occ", occupancy_o, 0);

        // Mode switch: slow A then fast B; B waits behind A
        mode_i  = 2'd1;
        valid_i = 1'b1;
        data_i  = 32'hB0;
        step();
        mode_i  = 2'd0;
        data_i  = 32'hB1;
        step();
        valid_i = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            check("sw_valid", valid_o, (c == 8 || c == 9));
            if (c == 8) check("sw_data_a", data_o, 32'hB0);
            if (c == 9) check("sw_data_b", data_o, 32'hB1);
            step();
        end

        // Simultaneous push and pop keeps occupancy at 1
        mode_i  = 2'd0;
        valid_i = 1'b1;
        data_i  = 32'h20;
        step();
        for (int c = 1; c <= 3; c++) begin
            data_i = 32'h20 + c;
            check("pp_valid", valid_o, 1);
            check("pp_data", data_o, 32'h20 + c - 1);
            check("pp_occ", occupancy_o, 1);
            step();
        end
        valid_i = 1'b0;
        check("pp_last_data", data_o, 32'h23);
        step();
        check("pp_end_occ", occupancy_o, 0);
        check("pp_end_valid", valid_o, 0);

        // Backpressure: hold 4 beats for 20 cycles, then drain
        ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            valid_i = 1'b1;
            data_i  = 32'h30 + c;
            step();
        end
        valid_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", valid_o, 1);
            check("bp_data", data_o, 32'h30);
            check("bp_occ", occupancy_o, 4);
            check("bp_ready", ready_o, 0);
            step();
        end
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_valid", valid_o, 1);
            check("bp_drain_data", data_o, 32'h30 + k);
            step();
        end
        check("bp_end_valid", valid_o, 0);
        check("bp_end_occ", occupancy_o, 0);

        // clear_i with 3 entries and a concurrent accept
        mode_i = 2'd1;
        for (int c = 0; c < 3; c++) begin
            valid_i = 1'b1;
            data_i  = 32'hD0 + c;
            step();
        end
        valid_i = 1'b0;
        step();
        step();
        check("clr_pre_occ", occupancy_o, 3);
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hEE;
        step();
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("clr_occ", occupancy_o, 0);
        check("clr_valid", valid_o, 0);
        check("clr_ready", ready_o, 1);
        for (int c = 0; c < 12; c++) begin
            check("clr_no_beat", valid_o, 0);
            step();
        end

        // Mixed mode right after clear: LFSR restarts from seed
        mixed_run(1000);

        // Asynchronous reset mid-stream
        mode_i = 2'd1;
        for (int c = 0; c < 3; c++) begin
            valid_i = 1'b1;
            data_i  = 32'hE0 + c;
            step();
        end
        valid_i = 1'b0;
        check("ar_pre_occ", occupancy_o, 3);
        rst_ni = 1'b0;
        #1;
        check("ar_occ", occupancy_o, 0);
        check("ar_valid", valid_o, 0);
        check("ar_ready", ready_o, 1);
        check("ar_data", data_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("ar_no_beat", valid_o, 0);
            step();
        end

        // LFSR back at seed after reset
        mixed_run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
